// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers completed FU results in per-FU FIFOs and broadcasts
// one per cycle on the common data bus, round-robin across FUs.
module cdb_arbiter #(
    parameter int unsigned NUM_FU     = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned PRF_IDX_W  = 6,
    parameter int unsigned ROB_IDX_W  = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic [NUM_FU-1:0]             fu_done_i,
    input  logic [NUM_FU*DATA_W-1:0]      fu_result_i,
    input  logic [NUM_FU*PRF_IDX_W-1:0]   fu_dest_tag_i,
    input  logic [NUM_FU*ROB_IDX_W-1:0]   fu_rob_idx_i,
    output logic [NUM_FU-1:0]             fu_ready_o,
    output logic                          cdb_valid_o,
    output logic [DATA_W-1:0]             cdb_value_o,
    output logic [PRF_IDX_W-1:0]          cdb_tag_o,
    output logic [ROB_IDX_W-1:0]          cdb_rob_idx_o,
    output logic                          overflow_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [DATA_W-1:0]    value;
        logic [PRF_IDX_W-1:0] tag;
        logic [ROB_IDX_W-1:0] rob_idx;
    } entry_t;

    entry_t             fifo_mem [NUM_FU][FIFO_DEPTH];
    entry_t             in_entry [NUM_FU];
    logic [PTR_W-1:0]   wr_ptr   [NUM_FU];
    logic [PTR_W-1:0]   rd_ptr   [NUM_FU];
    logic [CNT_W-1:0]   count    [NUM_FU];

    logic [NUM_FU-1:0]  push;
    logic [NUM_FU-1:0]  pop;
    logic [NUM_FU-1:0]  not_empty;
    logic               grant_valid;
    logic [FU_W-1:0]    grant_idx;
    logic [FU_W-1:0]    scan_idx;
    logic [FU_W-1:0]    rr_ptr;
    logic [FU_W-1:0]    rr_next;
    entry_t             head;

    // Per-FU ready/occupancy from registered count only, plus unpacked input entries
    always_comb begin
        fu_ready_o = '0;
        not_empty  = '0;
        push       = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready_o[i] = (count[i] < CNT_W'(FIFO_DEPTH));
            not_empty[i]  = (count[i] != '0);
            push[i]       = fu_done_i[i] && fu_ready_o[i] && !flush_i;
            in_entry[i].value   = fu_result_i[i*DATA_W +: DATA_W];
            in_entry[i].tag     = fu_dest_tag_i[i*PRF_IDX_W +: PRF_IDX_W];
            in_entry[i].rob_idx = fu_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W];
        end
    end

    // Round-robin scan of FIFO heads starting at rr_ptr
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        pop         = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            scan_idx = FU_W'((32'(rr_ptr) + k) % NUM_FU);
            if (!grant_valid && not_empty[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        if (grant_valid && !flush_i) begin
            pop[grant_idx] = 1'b1;
        end
        head    = fifo_mem[grant_idx][rd_ptr[grant_idx]];
        rr_next = (grant_idx == FU_W'(NUM_FU - 1)) ? '0 : grant_idx + FU_W'(1);
    end

    // FIFO pointers and occupancy; flush and reset empty every FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (flush_i) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= in_entry[i];
            end
        end
    end

    // CDB broadcast registers, round-robin pointer and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_o   <= 1'b0;
            cdb_value_o   <= '0;
            cdb_tag_o     <= '0;
            cdb_rob_idx_o <= '0;
            rr_ptr        <= '0;
            overflow_o    <= 1'b0;
        end else begin
            if (|(fu_done_i & ~fu_ready_o)) begin
                overflow_o <= 1'b1;
            end
            if (flush_i) begin
                cdb_valid_o <= 1'b0;
                rr_ptr      <= '0;
            end else if (grant_valid) begin
                cdb_valid_o   <= 1'b1;
                cdb_value_o   <= head.value;
                cdb_tag_o     <= head.tag;
                cdb_rob_idx_o <= head.rob_idx;
                rr_ptr        <= rr_next;
            end else begin
                cdb_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter with a cycle-level reference model.
module tb_cdb_arbiter;

    localparam int unsigned NF = 4;
    localparam int unsigned D  = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned TW = 6;
    localparam int unsigned RW = 5;

    typedef struct packed {
        logic [DW-1:0] v;
        logic [TW-1:0] t;
        logic [RW-1:0] r;
    } ent_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic [NF-1:0]       done;
    logic [NF*DW-1:0]    result;
    logic [NF*TW-1:0]    dtag;
    logic [NF*RW-1:0]    rob;
    logic [NF-1:0]       ready;
    logic                cvalid;
    logic [DW-1:0]       cvalue;
    logic [TW-1:0]       ctag;
    logic [RW-1:0]       crob;
    logic                ovf;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .fu_done_i     (done),
        .fu_result_i   (result),
        .fu_dest_tag_i (dtag),
        .fu_rob_idx_i  (rob),
        .fu_ready_o    (ready),
        .cdb_valid_o   (cvalid),
        .cdb_value_o   (cvalue),
        .cdb_tag_o     (ctag),
        .cdb_rob_idx_o (crob),
        .overflow_o    (ovf)
    );

    // Reference model state
    ent_t mmem [NF][D];
    int   mcnt [NF];
    int   mhead[NF];
    int   mrr;
    logic mvalid;
    logic mov;
    ent_t mlast;
    ent_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            mcnt[i]  = 0;
            mhead[i] = 0;
        end
        mrr    = 0;
        mvalid = 1'b0;
        mov    = 1'b0;
        mlast  = '0;
        exp_q.delete();
    endtask

    // Advance model by one clock edge using the inputs the DUT just sampled
    task automatic model_step();
        int   g;
        int   idx;
        logic [NF-1:0] rdy;
        ent_t e;
        g = -1;
        for (int i = 0; i < NF; i++) rdy[i] = (mcnt[i] < D);
        for (int k = 0; k < NF; k++) begin
            idx = (mrr + k) % NF;
            if (g < 0 && mcnt[idx] > 0) g = idx;
        end
        for (int i = 0; i < NF; i++) if (done[i] && !rdy[i]) mov = 1'b1;
        if (flush) begin
            for (int i = 0; i < NF; i++) begin
                mcnt[i]  = 0;
                mhead[i] = 0;
            end
            mrr    = 0;
            mvalid = 1'b0;
        end else begin
            if (g >= 0) begin
                e = mmem[g][mhead[g]];
                exp_q.push_back(e);
                mlast    = e;
                mvalid   = 1'b1;
                mhead[g] = (mhead[g] + 1) % D;
                mcnt[g]  = mcnt[g] - 1;
                mrr      = (g + 1) % NF;
            end else begin
                mvalid = 1'b0;
            end
            for (int i = 0; i < NF; i++) begin
                if (done[i] && rdy[i]) begin
                    e.v = result[i*DW +: DW];
                    e.t = dtag[i*TW +: TW];
                    e.r = rob[i*RW +: RW];
                    mmem[i][(mhead[i] + mcnt[i]) % D] = e;
                    mcnt[i] = mcnt[i] + 1;
                end
            end
        end
    endtask

    task automatic compare();
        ent_t e;
        logic [NF-1:0] mr;
        chk("valid", 128'(cvalid), 128'(mvalid));
        if (cvalid) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 128'(1), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk("value", 128'(cvalue), 128'(e.v));
                chk("tag",   128'(ctag),   128'(e.t));
                chk("rob",   128'(crob),   128'(e.r));
            end
        end else begin
            chk("hold_value", 128'(cvalue), 128'(mlast.v));
            chk("hold_tag",   128'(ctag),   128'(mlast.t));
        end
        for (int i = 0; i < NF; i++) mr[i] = (mcnt[i] < D);
        chk("ready",    128'(ready), 128'(mr));
        chk("overflow", 128'(ovf),   128'(mov));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        compare();
    endtask

    task automatic set_fu(input int i, input logic [DW-1:0] v, input logic [TW-1:0] t, input logic [RW-1:0] r);
        result[i*DW +: DW] = v;
        dtag[i*TW +: TW]   = t;
        rob[i*RW +: RW]    = r;
    endtask

    task automatic set_rand(input int i);
        set_fu(i, {$urandom, $urandom}, TW'($urandom_range(63)), RW'($urandom_range(31)));
    endtask

    initial begin
        rst_n  = 1'b0;
        flush  = 1'b0;
        done   = '0;
        result = '0;
        dtag   = '0;
        rob    = '0;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single result on FU1: two-edge latency, then idle
        set_fu(1, 64'h5, 6'd7, 5'd3);
        done = 4'b0010;
        tick();
        done = '0;
        tick();
        chk("t1_valid", 128'(cvalid), 128'(1));
        chk("t1_value", 128'(cvalue), 128'(64'h5));
        chk("t1_tag",   128'(ctag),   128'(7));
        chk("t1_rob",   128'(crob),   128'(3));
        tick();
        chk("t1_idle", 128'(cvalid), 128'(0));

        // rr_ptr now 2: FU1 and FU2 together -> FU2 wins first
        set_fu(1, 64'h11, 6'd21, 5'd1);
        set_fu(2, 64'h22, 6'd22, 5'd2);
        done = 4'b0110;
        tick();
        done = '0;
        tick();
        chk("rr_first", 128'(ctag), 128'(22));
        tick();
        chk("rr_second", 128'(ctag), 128'(21));
        tick();

        // All four from reset -> broadcast FU0..FU3 in order
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NF; i++) set_fu(i, {$urandom, $urandom}, TW'(10 + i), RW'(i));
        done = 4'hf;
        tick();
        done = '0;
        for (int i = 0; i < NF; i++) begin
            tick();
            chk("t2_order", 128'(ctag), 128'(10 + i));
        end
        tick();
        tick();

        // FU0 and FU2 stream while honouring ready
        for (int c = 0; c < 10; c++) begin
            set_rand(0);
            set_rand(2);
            done = {1'b0, ready[2], 1'b0, ready[0]};
            tick();
        end
        done = '0;
        repeat (6) tick();
        chk("t3_no_ovf", 128'(ovf), 128'(0));

        // FU3 ignores ready while all FUs stream -> overflow, sticky through flush
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NF; i++) set_rand(i);
            done = ready | 4'b1000;
            tick();
        end
        done = '0;
        chk("t4_ovf", 128'(ovf), 128'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_ovf_flush", 128'(ovf), 128'(1));
        repeat (3) tick();

        // Fill FIFOs, then flush with a concurrent FU1 done
        for (int i = 0; i < NF; i++) set_rand(i);
        done = 4'hf;
        tick();
        set_rand(0);
        done = 4'b0001;
        tick();
        set_rand(1);
        done  = 4'b0010;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        done  = '0;
        chk("t5_valid", 128'(cvalid), 128'(0));
        chk("t5_ready", 128'(ready),  128'(4'hf));
        repeat (4) tick();

        // Asynchronous reset between edges with entries pending
        for (int i = 0; i < NF; i++) set_rand(i);
        done = 4'hf;
        tick();
        done = '0;
        @(posedge clk);
        model_step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_valid", 128'(cvalid), 128'(0));
        chk("t6_ready", 128'(ready),  128'(4'hf));
        chk("t6_value", 128'(cvalue), 128'(0));
        chk("t6_ovf",   128'(ovf),    128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        set_rand(3);
        done = 4'b1000;
        tick();
        done = '0;
        tick();
        chk("t6_new", 128'(cvalid), 128'(1));
        tick();

        chk("sb_drain", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
